sdrc_wb_traffic_gen: RTL and testbench



---
 rtl/sdrc_tg_pkg.sv | 21 ++
 rtl/sdrc_tg_lfsr.sv | 17 +
 rtl/sdrc_wb_traffic_gen.sv | 156 +++++++++++++++
 tb/tb_sdrc_wb_traffic_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdrc_tg_pkg.sv
// sdrc_tg_pkg: shared types, bus constants and LFSR step for the SDRAM WB traffic generator
package sdrc_tg_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_INIT,
        S_WR_BURST,
        S_RD_BURST,
        S_GAP,
        S_DONE
    } state_t;
    localparam logic [2:0] CTI_INC = 3'b010;
    localparam logic [2:0] CTI_EOB = 3'b111;
    localparam logic [1:0] MODE_WR_RD = 2'b00;
    localparam logic [1:0] MODE_WR = 2'b01;
    localparam logic [1:0] MODE_RD = 2'b10;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] SEED_ZERO_SUB = 32'hFFFF_FFFF;
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction
endpackage

// File: rtl/sdrc_tg_lfsr.sv
// sdrc_tg_lfsr: 32-bit Galois LFSR (x^32+x^22+x^2+x+1) with load and advance
// ports: clk, rst_n (async, active-low), load/seed (load wins), adv (one step), value (current state)
module sdrc_tg_lfsr
    import sdrc_tg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        adv,
    input  logic [31:0] seed,
    output logic [31:0] value
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) value <= '0;
        else if (load) value <= seed;
        else if (adv) value <= lfsr_next(value);
endmodule

// File: rtl/sdrc_wb_traffic_gen.sv
// sdrc_wb_traffic_gen: Wishbone burst master writing/reading a self-checked LFSR pattern
// ports: wb_clk_i/wb_resetn clock and async active-low reset; start + cfg_* run setup (latched on start);
// wb_* Wishbone master interface; busy/done/timeout status; err_cnt/first_err_addr read-check results
module sdrc_wb_traffic_gen
    import sdrc_tg_pkg::*;
#(
    parameter int WB_AW   = 26,
    parameter int WB_DW   = 32,
    parameter int MAX_BL  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_resetn,
    input  logic                    sdr_init_done,
    input  logic                    start,
    input  logic [1:0]              cfg_mode,
    input  logic [WB_AW-1:0]        cfg_base_addr,
    input  logic [$clog2(MAX_BL):0] cfg_burst_len,
    input  logic [15:0]             cfg_num_bursts,
    input  logic [31:0]             cfg_seed,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [WB_AW-1:0]        wb_addr_o,
    output logic [WB_DW-1:0]        wb_dat_o,
    output logic [WB_DW/8-1:0]      wb_sel_o,
    output logic [2:0]              wb_cti_o,
    input  logic                    wb_ack_i,
    input  logic [WB_DW-1:0]        wb_dat_i,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [15:0]             err_cnt,
    output logic [WB_AW-1:0]        first_err_addr
);
    localparam int BLW = $clog2(MAX_BL) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT - 1);
    localparam logic [WB_AW-1:0] STEP = WB_AW'(WB_DW / 8);
    state_t state, state_nxt;
    logic [1:0] mode_q;
    logic [WB_AW-1:0] base_q, addr;
    logic [BLW-1:0] bl_q, beat;
    logic [15:0] nb_q, burst;
    logic [TW-1:0] wait_cnt;
    logic [31:0] wr_lfsr, rd_lfsr, seed_in;
    logic [WB_DW-1:0] wr_pat, exp_dat;
    logic rd_phase, in_burst, ack, accept, last_beat, last_burst, two_phase, tmo;
    assign in_burst = state == S_WR_BURST || state == S_RD_BURST;
    assign ack = in_burst && wb_ack_i;
    assign accept = state == S_IDLE && start;
    assign last_beat = beat == bl_q - 1'b1;
    // burst is bumped on the last ack, so in GAP it already counts the finished burst
    assign last_burst = burst == nb_q;
    assign two_phase = mode_q != MODE_WR && mode_q != MODE_RD;
    assign tmo = in_burst && !wb_ack_i && wait_cnt == WAIT_MAX;
    assign seed_in = cfg_seed == '0 ? SEED_ZERO_SUB : cfg_seed;
    // read checker never advances during the write phase, so loading both on start keeps them aligned
    sdrc_tg_lfsr u_wr_lfsr (
        .clk  (wb_clk_i),
        .rst_n(wb_resetn),
        .load (accept),
        .adv  (ack && state == S_WR_BURST),
        .seed (seed_in),
        .value(wr_lfsr)
    );
    sdrc_tg_lfsr u_rd_lfsr (
        .clk  (wb_clk_i),
        .rst_n(wb_resetn),
        .load (accept),
        .adv  (ack && state == S_RD_BURST),
        .seed (seed_in),
        .value(rd_lfsr)
    );
    generate
        if (WB_DW >= 32) begin : g_rep
            assign wr_pat = {(WB_DW / 32){wr_lfsr}};
            assign exp_dat = {(WB_DW / 32){rd_lfsr}};
        end else begin : g_trunc
            assign wr_pat = wr_lfsr[WB_DW-1:0];
            assign exp_dat = rd_lfsr[WB_DW-1:0];
        end
    endgenerate
    always_ff @(posedge wb_clk_i or negedge wb_resetn)
        if (!wb_resetn) state <= S_IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      state_nxt = start ? S_WAIT_INIT : S_IDLE;
            S_WAIT_INIT: state_nxt = !sdr_init_done ? S_WAIT_INIT : mode_q == MODE_RD ? S_RD_BURST : S_WR_BURST;
            S_WR_BURST,
            S_RD_BURST:  state_nxt = wb_ack_i ? (last_beat ? S_GAP : state) : (tmo ? S_DONE : state);
            S_GAP:       state_nxt = !last_burst ? (rd_phase ? S_RD_BURST : S_WR_BURST) :
                                     (two_phase && !rd_phase) ? S_RD_BURST : S_DONE;
            default:     state_nxt = S_IDLE;
        endcase
    end
    always_comb begin
        wb_cyc_o = in_burst;
        wb_stb_o = in_burst;
        wb_we_o = state == S_WR_BURST;
        wb_cti_o = !in_burst ? 3'b000 : last_beat ? CTI_EOB : CTI_INC;
        wb_addr_o = addr;
        wb_dat_o = wr_pat;
        wb_sel_o = '1;
        busy = state != S_IDLE && state != S_DONE;
        done = state == S_DONE;
    end
    always_ff @(posedge wb_clk_i or negedge wb_resetn)
        if (!wb_resetn) begin
            mode_q <= '0;
            base_q <= '0;
            addr <= '0;
            bl_q <= '0;
            nb_q <= '0;
            beat <= '0;
            burst <= '0;
            wait_cnt <= '0;
            rd_phase <= 1'b0;
            timeout <= 1'b0;
            err_cnt <= '0;
            first_err_addr <= '0;
        end else begin
            if (accept) begin
                mode_q <= cfg_mode;
                base_q <= cfg_base_addr;
                addr <= cfg_base_addr;
                bl_q <= cfg_burst_len == '0 ? BLW'(1) : cfg_burst_len > BLW'(MAX_BL) ? BLW'(MAX_BL) : cfg_burst_len;
                nb_q <= cfg_num_bursts == '0 ? 16'd1 : cfg_num_bursts;
                beat <= '0;
                burst <= '0;
                wait_cnt <= '0;
                rd_phase <= cfg_mode == MODE_RD;
                timeout <= 1'b0;
                err_cnt <= '0;
                first_err_addr <= '0;
            end
            if (in_burst) wait_cnt <= wb_ack_i ? '0 : wait_cnt + 1'b1;
            if (tmo) timeout <= 1'b1;
            if (ack) begin
                addr <= addr + STEP;
                beat <= last_beat ? '0 : beat + 1'b1;
                if (last_beat) burst <= burst + 1'b1;
            end
            if (ack && state == S_RD_BURST && wb_dat_i != exp_dat) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
                if (err_cnt == '0) first_err_addr <= addr;
            end
            if (state == S_GAP && last_burst && two_phase && !rd_phase) begin
                addr <= base_q;
                burst <= '0;
                rd_phase <= 1'b1;
            end
        end
endmodule

// File: tb/tb_sdrc_wb_traffic_gen.sv
// tb_sdrc_wb_traffic_gen: scoreboard bench for the WB traffic generator against a memory slave model
module tb_sdrc_wb_traffic_gen;
    typedef struct packed {
        logic        we;
        logic [25:0] addr;
        logic [31:0] dat;
        logic [2:0]  cti;
    } beat_t;
    logic clk = 0, rst_n = 0, init_done = 1, start = 0, ack_en = 1;
    logic [1:0] cfg_mode = 0;
    logic [25:0] cfg_base = 0;
    logic [4:0] cfg_bl = 0;
    logic [15:0] cfg_nb = 0;
    logic [31:0] cfg_seed = 0;
    logic cyc, stb, we, ack, busy, done, timeout;
    logic [25:0] addr, first_err;
    logic [31:0] wdat, rdat;
    logic [3:0] sel;
    logic [2:0] cti;
    logic [15:0] err_cnt;
    logic [31:0] mem [256];
    int corrupt_at = -1, rd_beat = 0;
    int checks = 0, errors = 0;
    int low_cnt = 0;
    logic had_cyc = 0, wr_seen = 0;
    logic [31:0] first_wdat = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    sdrc_wb_traffic_gen dut (
        .wb_clk_i(clk), .wb_resetn(rst_n), .sdr_init_done(init_done), .start(start),
        .cfg_mode(cfg_mode), .cfg_base_addr(cfg_base), .cfg_burst_len(cfg_bl),
        .cfg_num_bursts(cfg_nb), .cfg_seed(cfg_seed), .wb_cyc_o(cyc), .wb_stb_o(stb),
        .wb_we_o(we), .wb_addr_o(addr), .wb_dat_o(wdat), .wb_sel_o(sel), .wb_cti_o(cti),
        .wb_ack_i(ack), .wb_dat_i(rdat), .busy(busy), .done(done), .timeout(timeout),
        .err_cnt(err_cnt), .first_err_addr(first_err)
    );

    assign ack = cyc && stb && ack_en;
    assign rdat = mem[addr[9:2]] ^ ((rd_beat == corrupt_at) ? 32'h1 : 32'h0);

    always @(posedge clk) begin
        if (ack && we) mem[addr[9:2]] <= wdat;
        if (start) rd_beat <= 0;
        else if (ack && !we) rd_beat <= rd_beat + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            had_cyc <= 0;
            low_cnt <= 0;
            wr_seen <= 0;
        end else begin
            if (ack) begin
                if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    b = exp_q.pop_front();
                    chk("beat_addr", addr, b.addr);
                    chk("beat_we", we, b.we);
                    chk("beat_cti", cti, b.cti);
                    if (b.we) chk("beat_wdat", wdat, b.dat);
                    if (b.we && !wr_seen) first_wdat <= wdat;
                    if (b.we) wr_seen <= 1;
                end
            end
            if (cyc) begin
                if (low_cnt != 0) chk("gap_len", low_cnt, 1);
                low_cnt <= 0;
                had_cyc <= 1;
            end else if (!busy) begin
                had_cyc <= 0;
                low_cnt <= 0;
                wr_seen <= 0;
            end else if (had_cyc) low_cnt <= low_cnt + 1;
        end
    end

    task automatic push_exp(input logic [1:0] mode, input logic [25:0] base, input int bl,
                            input int nb, input logic [31:0] seed);
        int ebl = bl == 0 ? 1 : (bl > 16 ? 16 : bl);
        int enb = nb == 0 ? 1 : nb;
        logic [31:0] s;
        logic [25:0] a;
        beat_t b;
        for (int p = 0; p < 2; p++) begin
            if (p == 0 && mode == 2'b10) continue;
            if (p == 1 && mode == 2'b01) continue;
            s = seed == 0 ? 32'hFFFF_FFFF : seed;
            a = base;
            for (int i = 0; i < enb; i++)
                for (int k = 0; k < ebl; k++) begin
                    b.we = (p == 0);
                    b.addr = a;
                    b.dat = s;
                    b.cti = (k == ebl - 1) ? 3'b111 : 3'b010;
                    exp_q.push_back(b);
                    s = m_next(s);
                    a = a + 26'd4;
                end
        end
        cfg_mode = mode;
        cfg_base = base;
        cfg_bl = 5'(bl);
        cfg_nb = 16'(nb);
        cfg_seed = seed;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    task automatic wait_done(input bit extra_start);
        bit got = 0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            start = extra_start && i == 5;
            got = done;
        end
        start = 0;
        chk("done_seen", got, 1);
        chk("busy_at_done", busy, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run(input logic [1:0] mode, input logic [25:0] base, input int bl,
                       input int nb, input logic [31:0] seed, input bit extra_start);
        push_exp(mode, base, bl, nb, seed);
        pulse_start();
        wait_done(extra_start);
    endtask

    initial begin
        int cnt;
        bit got;
        for (int i = 0; i < 256; i++) mem[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", {cyc, stb, we, busy, done, timeout}, 0);
        chk("rst_addr_dat", {addr, wdat, cti}, 0);
        chk("rst_err", {err_cnt, first_err}, 0);
        rst_n = 1;
        @(negedge clk);
        // two bursts of 4 write-then-read, with an ignored start in the middle
        run(2'b00, 26'h100, 4, 2, 32'h1, 1);
        chk("t1_err_cnt", err_cnt, 0);
        chk("t1_timeout", timeout, 0);
        chk("t1_first_wdat", first_wdat, 32'h1);
        corrupt_at = 2;
        run(2'b00, 26'h100, 4, 2, 32'h1, 0);
        corrupt_at = -1;
        chk("t2_err_cnt", err_cnt, 1);
        chk("t2_first_err", first_err, 26'h108);
        // zero burst length and zero burst count degrade to 1, oversize burst clamps to 16
        run(2'b01, 26'h0, 0, 2, 32'h7, 0);
        run(2'b01, 26'h400, 20, 0, 32'h9, 0);
        // address wrap, then read-only check of the same region
        run(2'b01, 26'h3FF_FFF8, 4, 1, 32'h1234_5678, 0);
        run(2'b10, 26'h3FF_FFF8, 4, 1, 32'h1234_5678, 0);
        chk("t4_ro_err_cnt", err_cnt, 0);
        // slave never acks
        ack_en = 0;
        cfg_mode = 2'b01;
        cfg_bl = 4;
        cfg_nb = 1;
        pulse_start();
        cnt = 0;
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (cyc) cnt++;
            got = done;
        end
        chk("tmo_done_seen", got, 1);
        chk("tmo_cyc_cycles", cnt, 1024);
        chk("tmo_flags", {cyc, timeout, busy}, 3'b010);
        ack_en = 1;
        // reset mid-burst
        push_exp(2'b00, 26'h200, 8, 4, 32'h5);
        pulse_start();
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_ctl", {cyc, stb, we, busy, done, timeout}, 0);
        chk("mid_rst_bus", {addr, wdat, cti}, 0);
        exp_q.delete();
        @(negedge clk) rst_n = 1;
        @(negedge clk);
        run(2'b00, 26'h100, 4, 2, 32'h1, 0);
        chk("post_rst_err_cnt", err_cnt, 0);
        chk("timeout_cleared", timeout, 0);
        // init held low, zero seed
        init_done = 0;
        push_exp(2'b01, 26'h40, 2, 1, 32'h0);
        pulse_start();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cyc) cnt++;
        end
        chk("no_cyc_before_init", cnt, 0);
        chk("busy_waiting_init", busy, 1);
        init_done = 1;
        wait_done(0);
        chk("seed0_first_wdat", first_wdat, 32'hFFFF_FFFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
